// File: rtl/cv32e40p_fetch_queue.sv
// Instruction fetch queue for the IF stage.
//
// Issues word-aligned OBI instruction requests with up to MAX_OUTSTANDING
// granted-but-unreturned transactions. Responses land in a FIFO_DEPTH-entry
// FIFO presented to the aligner through a valid/ready handshake. A branch
// flushes the FIFO, marks in-flight responses for discard and redirects
// fetch without disturbing an ungranted OBI request.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_i                    fetching enabled
//   branch_i, branch_addr_i  single-cycle redirect and its target
//   fetch_valid_o/ready_i    head-of-FIFO handshake to the aligner
//   fetch_rdata_o/addr_o     head instruction word and its word address
//   fetch_err_o              head response carried a bus error
//   instr_req_o/addr_o/gnt_i OBI address phase
//   instr_rvalid_i/rdata_i/err_i  OBI response phase
//   busy_o                   request pending or response outstanding
module cv32e40p_fetch_queue #(
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        fetch_valid_o,
  input  logic        fetch_ready_i,
  output logic [31:0] fetch_rdata_o,
  output logic [31:0] fetch_addr_o,
  output logic        fetch_err_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  output logic        busy_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {StIdle, StReq, StBwait} state_e;

  state_e          r_state, w_state_d;
  logic [31:0]     r_addr, w_addr_d;        // address of the held (ungranted) request
  logic [31:0]     r_next_addr, w_next_addr_d;
  logic [31:0]     r_baddr, w_baddr_d;      // latched branch target
  logic            r_pend, w_pend_d;        // branch target still to be issued
  logic [OW-1:0]   r_cnt_out, w_cnt_out_d;
  logic [OW-1:0]   r_cnt_disc, w_cnt_disc_d;
  logic [CW-1:0]   r_fifo_cnt;
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [31:0]     r_resp_addr;             // address of the next response to be kept
  logic [31:0]     r_data  [FIFO_DEPTH];
  logic [31:0]     r_faddr [FIFO_DEPTH];
  logic            r_err   [FIFO_DEPTH];
  logic            r_hold;
  logic [31:0]     r_hold_addr;

  logic [31:0]     w_target;
  logic [31:0]     w_req_addr;
  logic [31:0]     w_occ;
  logic            w_cnt_ok, w_credit;
  logic            w_gnt, w_gnt_old;
  logic            w_push, w_pop, w_drop;
  logic            w_unused_addr_bits;

  assign w_target           = {branch_addr_i[31:2], 2'b00};
  assign w_unused_addr_bits = ^branch_addr_i[1:0];

  assign fetch_valid_o = (r_fifo_cnt != '0);
  assign fetch_rdata_o = fetch_valid_o ? r_data[r_rptr]  : '0;
  assign fetch_addr_o  = fetch_valid_o ? r_faddr[r_rptr] : '0;
  assign fetch_err_o   = fetch_valid_o ? r_err[r_rptr]   : 1'b0;

  // A pop this cycle frees a slot before any new response can arrive, so it
  // counts towards credit; this is what sustains one word per cycle at depth 2.
  assign w_pop    = fetch_valid_o & fetch_ready_i & ~branch_i;
  assign w_occ    = 32'(r_cnt_out) - 32'(r_cnt_disc) + 32'(r_fifo_cnt) - 32'(w_pop);
  assign w_cnt_ok = (r_cnt_out < OW'(MAX_OUTSTANDING));
  assign w_credit = (w_occ < FIFO_DEPTH) && w_cnt_ok;

  assign w_gnt     = instr_req_o & instr_gnt_i;
  // Any grant outside IDLE belongs to a request issued before the branch.
  assign w_gnt_old = w_gnt & (r_state != StIdle);
  assign w_drop    = instr_rvalid_i & ~branch_i & (r_cnt_disc != '0);
  assign w_push    = instr_rvalid_i & ~branch_i & (r_cnt_disc == '0);

  assign instr_addr_o = w_req_addr;
  assign busy_o       = instr_req_o | (r_cnt_out != '0);

  always_comb begin
    instr_req_o   = 1'b0;
    w_req_addr    = r_next_addr;
    w_state_d     = r_state;
    w_addr_d      = r_addr;
    w_next_addr_d = r_next_addr;
    w_baddr_d     = r_baddr;
    w_pend_d      = r_pend;
    unique case (r_state)
      StIdle: begin
        if (branch_i) begin
          instr_req_o = w_cnt_ok;
          w_req_addr  = w_target;
          w_baddr_d   = w_target;
          w_pend_d    = ~w_cnt_ok;
        end else if (r_pend) begin
          instr_req_o = w_cnt_ok;
          w_req_addr  = r_baddr;
        end else begin
          instr_req_o = req_i & w_credit;
          w_req_addr  = r_next_addr;
        end
        if (instr_req_o) begin
          w_pend_d = 1'b0;
          if (instr_gnt_i) begin
            w_next_addr_d = w_req_addr + 32'd4;
          end else begin
            w_state_d = StReq;
            w_addr_d  = w_req_addr;
          end
        end
      end
      StReq: begin
        instr_req_o = 1'b1;
        w_req_addr  = r_addr;
        if (branch_i) begin
          w_baddr_d = w_target;
          if (instr_gnt_i) begin
            w_state_d = StIdle;
            w_pend_d  = 1'b1;
          end else begin
            w_state_d = StBwait;
          end
        end else if (instr_gnt_i) begin
          w_state_d     = StIdle;
          w_next_addr_d = r_addr + 32'd4;
        end
      end
      StBwait: begin
        // Old request must stay on the bus until granted; its response is dropped.
        instr_req_o = 1'b1;
        w_req_addr  = r_addr;
        if (branch_i) begin
          w_baddr_d = w_target;
        end
        if (instr_gnt_i) begin
          w_state_d = StIdle;
          w_pend_d  = 1'b1;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    w_cnt_out_d = r_cnt_out + OW'(w_gnt) - OW'(instr_rvalid_i);
    if (branch_i) begin
      w_cnt_disc_d = r_cnt_out + OW'(w_gnt_old) - OW'(instr_rvalid_i);
    end else begin
      w_cnt_disc_d = r_cnt_disc - OW'(w_drop) + OW'(w_gnt & (r_state == StBwait));
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_baddr     <= '0;
      r_pend      <= 1'b0;
      r_cnt_out   <= '0;
      r_cnt_disc  <= '0;
      r_fifo_cnt  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_resp_addr <= '0;
      r_hold      <= 1'b0;
      r_hold_addr <= '0;
    end else begin
      r_state     <= w_state_d;
      r_addr      <= w_addr_d;
      r_next_addr <= w_next_addr_d;
      r_baddr     <= w_baddr_d;
      r_pend      <= w_pend_d;
      r_cnt_out   <= w_cnt_out_d;
      r_cnt_disc  <= w_cnt_disc_d;
      r_hold      <= instr_req_o & ~instr_gnt_i;
      r_hold_addr <= instr_addr_o;
      if (branch_i) begin
        r_fifo_cnt  <= '0;
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_resp_addr <= w_target;
      end else begin
        r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
        if (w_push) begin
          r_wptr      <= ptr_inc(r_wptr);
          r_resp_addr <= r_resp_addr + 32'd4;
        end
        if (w_pop) begin
          r_rptr <= ptr_inc(r_rptr);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wptr]  <= instr_rdata_i;
      r_faddr[r_wptr] <= r_resp_addr;
      r_err[r_wptr]   <= instr_err_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(instr_rvalid_i && (r_cnt_out == '0)));
      assert (r_fifo_cnt <= CW'(FIFO_DEPTH));
      assert (!r_hold || (instr_req_o && (instr_addr_o == r_hold_addr)));
    end
  end

endmodule

// File: tb/tb_cv32e40p_fetch_queue.sv
// Directed self-checking bench for cv32e40p_fetch_queue (default parameters).
// A small OBI responder returns data = address ^ KEY one cycle after grant
// while rsp_en is set; gnt is driven from gnt_en.
module tb_cv32e40p_fetch_queue;

  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, branch_i, fetch_ready_i;
  logic [31:0] branch_addr_i;
  logic        fetch_valid_o, fetch_err_o;
  logic [31:0] fetch_rdata_o, fetch_addr_o;
  logic        instr_req_o, instr_gnt_i, busy_o;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i  = '0;
  logic        instr_err_i    = 1'b0;

  logic        gnt_en, rsp_en;
  logic [31:0] err_addr;
  logic [31:0] rsp_q [$];
  int unsigned gnt_count = 0;
  int unsigned g0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign instr_gnt_i = gnt_en;

  cv32e40p_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_err_o    (fetch_err_o),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_err_i    (instr_err_i),
    .busy_o         (busy_o)
  );

  always @(posedge clk) begin
    if (rst) begin
      rsp_q.delete();
      instr_rvalid_i <= 1'b0;
      instr_err_i    <= 1'b0;
    end else begin
      if (instr_req_o && instr_gnt_i) begin
        rsp_q.push_back(instr_addr_o);
        gnt_count <= gnt_count + 1;
      end
      if (rsp_en && (rsp_q.size() != 0)) begin
        instr_rvalid_i <= 1'b1;
        instr_rdata_i  <= rsp_q[0] ^ KEY;
        instr_err_i    <= (rsp_q[0] == err_addr);
        void'(rsp_q.pop_front());
      end else begin
        instr_rvalid_i <= 1'b0;
        instr_err_i    <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    req_i = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("drain_busy", busy_o, 0);
    chk("drain_valid", fetch_valid_o, 0);
  endtask

  initial begin
    rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0;
    fetch_ready_i = 1'b1; gnt_en = 1'b1; rsp_en = 1'b1; err_addr = 32'hFFFF_FFFF;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", instr_req_o, 0);
    chk("rst_valid", fetch_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rdata", fetch_rdata_o, 0);
    chk("rst_faddr", fetch_addr_o, 0);
    chk("rst_err", fetch_err_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming from a branch to 0x100 (low target bits ignored)
    @(negedge clk);
    req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h0000_0103;
    #1;
    chk("str_req0", instr_req_o, 1);
    chk("str_iaddr0", instr_addr_o, 32'h100);
    @(negedge clk);
    branch_i = 1'b0;
    #1;
    chk("str_iaddr1", instr_addr_o, 32'h104);
    chk("str_valid1", fetch_valid_o, 0);
    @(negedge clk); #1;
    chk("str_valid2", fetch_valid_o, 1);
    chk("str_faddr2", fetch_addr_o, 32'h100);
    chk("str_rdata2", fetch_rdata_o, 32'h100 ^ KEY);
    @(negedge clk); #1;
    chk("str_faddr3", fetch_addr_o, 32'h104);
    @(negedge clk); #1;
    chk("str_faddr4", fetch_addr_o, 32'h108);
    chk("str_rdata4", fetch_rdata_o, 32'h108 ^ KEY);
    drain();

    // Backpressure: two grants then stop; release resumes at next word
    g0 = gnt_count;
    @(negedge clk);
    fetch_ready_i = 1'b0; req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h400;
    @(negedge clk);
    branch_i = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("bp_grants", gnt_count - g0, 2);
    chk("bp_req", instr_req_o, 0);
    chk("bp_valid", fetch_valid_o, 1);
    chk("bp_faddr", fetch_addr_o, 32'h400);
    chk("bp_busy", busy_o, 0);
    @(negedge clk);
    fetch_ready_i = 1'b1;
    #1;
    chk("bp_resume_req", instr_req_o, 1);
    chk("bp_resume_iaddr", instr_addr_o, 32'h408);
    @(negedge clk); #1;
    chk("bp_faddr1", fetch_addr_o, 32'h404);
    @(negedge clk); #1;
    chk("bp_faddr2", fetch_addr_o, 32'h408);
    drain();

    // Discard: branch to 0x200 with 0x100/0x104 outstanding
    @(negedge clk);
    rsp_en = 1'b0; req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h100;
    @(negedge clk);
    branch_i = 1'b0;
    @(negedge clk);
    branch_i = 1'b1; branch_addr_i = 32'h200;
    #1;
    chk("dis_req_full", instr_req_o, 0);
    chk("dis_busy", busy_o, 1);
    @(negedge clk);
    branch_i = 1'b0; rsp_en = 1'b1;
    @(negedge clk); #1;
    chk("dis_valid4", fetch_valid_o, 0);
    @(negedge clk); #1;
    chk("dis_req5", instr_req_o, 1);
    chk("dis_iaddr5", instr_addr_o, 32'h200);
    chk("dis_valid5", fetch_valid_o, 0);
    @(negedge clk); #1;
    chk("dis_valid6", fetch_valid_o, 0);
    @(negedge clk); #1;
    chk("dis_valid7", fetch_valid_o, 1);
    chk("dis_faddr7", fetch_addr_o, 32'h200);
    chk("dis_rdata7", fetch_rdata_o, 32'h200 ^ KEY);
    @(negedge clk); #1;
    chk("dis_faddr8", fetch_addr_o, 32'h204);
    drain();

    // Branch while waiting for grant
    @(negedge clk);
    gnt_en = 1'b0; req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h100;
    #1;
    chk("bw_iaddr0", instr_addr_o, 32'h100);
    @(negedge clk);
    branch_addr_i = 32'h300;
    #1;
    chk("bw_iaddr1", instr_addr_o, 32'h100);
    @(negedge clk);
    branch_i = 1'b0;
    #1;
    chk("bw_req2", instr_req_o, 1);
    chk("bw_iaddr2", instr_addr_o, 32'h100);
    @(negedge clk);
    gnt_en = 1'b1;
    #1;
    chk("bw_iaddr3", instr_addr_o, 32'h100);
    @(negedge clk); #1;
    chk("bw_req4", instr_req_o, 1);
    chk("bw_iaddr4", instr_addr_o, 32'h300);
    @(negedge clk); #1;
    chk("bw_valid5", fetch_valid_o, 0);
    @(negedge clk); #1;
    chk("bw_valid6", fetch_valid_o, 1);
    chk("bw_faddr6", fetch_addr_o, 32'h300);
    drain();

    // Error response on 0x104
    @(negedge clk);
    err_addr = 32'h104; req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h100;
    @(negedge clk);
    branch_i = 1'b0;
    @(negedge clk); #1;
    chk("err_faddr2", fetch_addr_o, 32'h100);
    chk("err_err2", fetch_err_o, 0);
    @(negedge clk); #1;
    chk("err_faddr3", fetch_addr_o, 32'h104);
    chk("err_err3", fetch_err_o, 1);
    @(negedge clk); #1;
    chk("err_faddr4", fetch_addr_o, 32'h108);
    chk("err_err4", fetch_err_o, 0);
    chk("err_rdata4", fetch_rdata_o, 32'h108 ^ KEY);
    drain();
    err_addr = 32'hFFFF_FFFF;

    // Reset with two outstanding requests, both marked for discard
    @(negedge clk);
    rsp_en = 1'b0; req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h600;
    @(negedge clk);
    branch_i = 1'b0;
    @(negedge clk);
    req_i = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h700;
    #1;
    chk("rmid_busy", busy_o, 1);
    chk("rmid_cnt_out", 32'(dut.r_cnt_out), 2);
    @(negedge clk);
    branch_i = 1'b0;
    #1;
    chk("rmid_cnt_disc", 32'(dut.r_cnt_disc), 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rmid_req", instr_req_o, 0);
    chk("rmid_valid", fetch_valid_o, 0);
    chk("rmid_busy0", busy_o, 0);
    chk("rmid_faddr", fetch_addr_o, 0);
    chk("rmid_cnt_out0", 32'(dut.r_cnt_out), 0);
    chk("rmid_cnt_disc0", 32'(dut.r_cnt_disc), 0);
    @(negedge clk);
    rst = 1'b0; rsp_en = 1'b1;
    @(negedge clk);
    req_i = 1'b1;
    #1;
    chk("post_rst_req", instr_req_o, 1);
    chk("post_rst_iaddr", instr_addr_o, 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("post_rst_valid", fetch_valid_o, 1);
    chk("post_rst_faddr", fetch_addr_o, 32'h0);
    chk("post_rst_rdata", fetch_rdata_o, KEY);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
